stopwatch_ctrl: RTL and testbench

Four-digit BCD stopwatch controller: takes debounced single-cycle button pulses (start/stop, lap, clear) and sequences a cascaded chain of decimal digit counters through idle, run, lap and stop states. It contains a tick prescaler, the enable-chained BCD digits (0000-9999), and a lap-freeze display register. It sits between the button-conditioning logic and the seven-segment display driver, and is the control layer for the enable-chained BCD counter datapath.

---
 rtl/stopwatch_ctrl.sv | 132 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch controller: button-driven IDLE/RUN/LAP/STOP sequencer
// with tick prescaler, enable-chained decimal digits and a lap-freeze display register.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        ar,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clr,
  output logic [15:0] cnt,
  output logic [15:0] disp,
  output logic        running,
  output logic        lapped,
  output logic        ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_pre;
  logic [PW-1:0]   w_pre_nxt;
  logic [3:0]      r_dig [4];
  logic [3:0]      w_dig_nxt [4];
  logic [15:0]     r_lap;
  logic            r_ovf;
  logic            w_lap_cap;
  logic            w_clear;
  logic            w_counting;
  logic            w_tick;
  logic [4:0]      w_en;

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Each state lists its legal pulses in priority order, so an illegal
  // higher-priority pulse never masks a legal lower-priority one.
  always_comb begin
    w_state_nxt = r_state;
    w_lap_cap   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_stop) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start_stop) begin
          w_state_nxt = S_STOP;
        end else if (lap) begin
          w_state_nxt = S_LAP;
          w_lap_cap   = 1'b1;
        end
      end
      S_LAP: begin
        if (start_stop)  w_state_nxt = S_STOP;
        else if (lap)    w_state_nxt = S_RUN;
      end
      S_STOP: begin
        if (start_stop) begin
          w_state_nxt = S_RUN;
        end else if (clr) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick decision uses the pre-edge state, so a stopping edge still applies it.
  always_comb begin
    w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    w_tick     = w_counting && (r_pre == PRE_MAX);
    w_pre_nxt  = r_pre;
    if (w_clear || (r_state == S_IDLE)) begin
      w_pre_nxt = '0;
    end else if (w_tick) begin
      w_pre_nxt = '0;
    end else if (w_counting) begin
      w_pre_nxt = r_pre + PW'(1);
    end
  end

  always_comb begin
    w_en[0] = w_tick;
    for (int i = 0; i < 4; i++) begin
      w_en[i+1] = w_en[i] && (r_dig[i] == 4'd9);
      if (w_clear) begin
        w_dig_nxt[i] = 4'd0;
      end else if (w_en[i]) begin
        w_dig_nxt[i] = (r_dig[i] >= 4'd9) ? 4'd0 : r_dig[i] + 4'd1;
      end else begin
        w_dig_nxt[i] = r_dig[i];
      end
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_pre <= '0;
      r_lap <= 16'h0000;
      r_ovf <= 1'b0;
      for (int i = 0; i < 4; i++) r_dig[i] <= 4'd0;
    end else begin
      r_pre <= w_pre_nxt;
      r_ovf <= w_en[4];
      if (w_lap_cap) r_lap <= cnt;
      for (int i = 0; i < 4; i++) r_dig[i] <= w_dig_nxt[i];
    end
  end

  assign cnt     = {r_dig[3], r_dig[2], r_dig[1], r_dig[0]};
  assign disp    = (r_state == S_LAP) ? r_lap : cnt;
  assign running = (r_state == S_RUN) || (r_state == S_LAP);
  assign lapped  = (r_state == S_LAP);
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV = 4: rate, pause phase, lap,
// clear rules, 9999 wrap and asynchronous reset.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        ar;
  logic        start_stop;
  logic        lap;
  logic        clr;
  logic [15:0] cnt;
  logic [15:0] disp;
  logic        running;
  logic        lapped;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .ar         (ar),
    .start_stop (start_stop),
    .lap        (lap),
    .clr        (clr),
    .cnt        (cnt),
    .disp       (disp),
    .running    (running),
    .lapped     (lapped),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    ar = 1'b1; start_stop = 1'b0; lap = 1'b0; clr = 1'b0;
    #3;
    check("rst_cnt",     cnt,               16'h0000);
    check("rst_disp",    disp,              16'h0000);
    check("rst_running", {15'd0, running},  16'd0);
    check("rst_lapped",  {15'd0, lapped},   16'd0);
    check("rst_ovf",     {15'd0, ovf},      16'd0);
    @(negedge clk);
    ar = 1'b0;
    step(1);

    // count rate
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("start_running", {15'd0, running}, 16'd1);
    check("start_cnt0",    cnt, 16'h0000);
    step(3);
    check("edge3_cnt",     cnt, 16'h0000);
    step(1);
    check("edge4_cnt",     cnt, 16'h0001);
    step(36);
    check("edge40_cnt",    cnt, 16'h0010);
    check("edge40_disp",   disp, 16'h0010);

    // pause with prescaler held at 2, resume
    step(1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("stop_running", {15'd0, running}, 16'd0);
    check("stop_cnt",     cnt, 16'h0010);
    step(100);
    check("paused_cnt",   cnt, 16'h0010);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("resume_running", {15'd0, running}, 16'd1);
    check("resume_cnt",     cnt, 16'h0010);
    step(1);
    check("resume_plus1",   cnt, 16'h0010);
    step(1);
    check("resume_plus2",   cnt, 16'h0011);

    // lap freeze
    step(124);
    check("pre_lap_cnt", cnt, 16'h0042);
    lap = 1'b1; step(1); lap = 1'b0;
    check("lap_lapped",  {15'd0, lapped}, 16'd1);
    check("lap_running", {15'd0, running}, 16'd1);
    check("lap_disp",    disp, 16'h0042);
    step(8);
    check("lap_cnt_adv",  cnt, 16'h0044);
    check("lap_disp_hold", disp, 16'h0042);
    lap = 1'b1; step(1); lap = 1'b0;
    check("unlap_lapped", {15'd0, lapped}, 16'd0);
    check("unlap_disp",   disp, 16'h0044);

    // clear rules
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_run_cnt",     cnt, 16'h0044);
    check("clr_run_running", {15'd0, running}, 16'd1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("stop_tick_cnt",   cnt, 16'h0045);
    check("stop_tick_run",   {15'd0, running}, 16'd0);
    start_stop = 1'b1; clr = 1'b1; step(1); start_stop = 1'b0; clr = 1'b0;
    check("ss_clr_running",  {15'd0, running}, 16'd1);
    check("ss_clr_cnt",      cnt, 16'h0045);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("stop2_running",   {15'd0, running}, 16'd0);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_stop_cnt",    cnt, 16'h0000);
    check("clr_stop_disp",   disp, 16'h0000);
    check("clr_stop_run",    {15'd0, running}, 16'd0);
    lap = 1'b1; step(1); lap = 1'b0;
    check("idle_lap_ign",    {15'd0, lapped}, 16'd0);

    // wrap 9999 -> 0000
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(39996);
    check("wrap_9999",     cnt, 16'h9999);
    check("wrap_ovf_pre",  {15'd0, ovf}, 16'd0);
    step(3);
    check("wrap_9999_hold", cnt, 16'h9999);
    step(1);
    check("wrap_cnt0",     cnt, 16'h0000);
    check("wrap_ovf",      {15'd0, ovf}, 16'd1);
    check("wrap_running",  {15'd0, running}, 16'd1);
    step(1);
    check("wrap_ovf_post", {15'd0, ovf}, 16'd0);

    // asynchronous reset mid-run
    step(547);
    check("pre_ar_cnt", cnt, 16'h0137);
    #2 ar = 1'b1;
    #1;
    check("ar_cnt",     cnt, 16'h0000);
    check("ar_disp",    disp, 16'h0000);
    check("ar_running", {15'd0, running}, 16'd0);
    check("ar_lapped",  {15'd0, lapped}, 16'd0);
    check("ar_ovf",     {15'd0, ovf}, 16'd0);
    #2 ar = 1'b0;
    step(1);
    check("post_ar_running", {15'd0, running}, 16'd0);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    check("restart_running", {15'd0, running}, 16'd1);
    check("restart_cnt0",    cnt, 16'h0000);
    step(4);
    check("restart_cnt1",    cnt, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
